// File: rtl/wb_uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and
// oversampling counter sizing. Also intended for the matching TX stage.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_e;

   // Width of a counter that runs 0 .. ticks-1.
   function automatic int cnt_width(input int ticks);
      return (ticks > 1) ? $clog2(ticks) : 1;
   endfunction

endpackage

// File: rtl/wb_uart_rx_if.sv
// Byte output side of the UART receiver: strobe/ack byte handoff plus error pulses.
interface wb_uart_rx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] wb_dat_o;
   logic                      wb_stb_o;
   logic                      wb_ack_i;
   logic                      err_frame_o;
   logic                      err_overrun_o;

   modport master (
      output wb_dat_o, wb_stb_o, err_frame_o, err_overrun_o,
      input  wb_ack_i
   );

   modport slave (
      input  wb_dat_o, wb_stb_o, err_frame_o, err_overrun_o,
      output wb_ack_i
   );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like activity after reset.
module uart_sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two real stages.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver: oversampled frame recovery, strobe/ack byte output,
// framing-error and overrun pulses.
module wb_uart_rx
   import uart_pkg::*;
#(
   parameter int TICKS_PER_BAUD = 8,
   parameter bit DATA_INVERT    = 1'b1
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             uart_rx,
   wb_uart_rx_if.master     bus
);
   localparam int CW = cnt_width(TICKS_PER_BAUD);
   localparam int BW = $clog2(UART_DATA_BITS);
   localparam logic [CW-1:0] C_HALF = CW'(TICKS_PER_BAUD / 2 - 1);
   localparam logic [CW-1:0] C_LAST = CW'(TICKS_PER_BAUD - 1);
   localparam logic [BW-1:0] B_LAST = BW'(UART_DATA_BITS - 1);

   rx_state_e                 r_state;
   rx_state_e                 w_next;
   logic [CW-1:0]             r_cnt;
   logic [BW-1:0]             r_bit_idx;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] r_dat;
   logic                      r_stb;
   logic                      r_err_frame;
   logic                      r_err_ovr;

   logic w_rx_s;
   logic w_cnt_clr;
   logic w_cnt_inc;
   logic w_shift_en;
   logic w_byte_done;
   logic w_frame_err;

   uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_ni),
      .i_d     (uart_rx),
      .o_q     (w_rx_s)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) r_state <= IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:      if (!w_rx_s) w_next = START;
         START:     if (r_cnt == C_HALF) w_next = w_rx_s ? IDLE : DATA;
         DATA:      if (r_cnt == C_LAST && r_bit_idx == B_LAST) w_next = STOP;
         STOP:      if (r_cnt == C_LAST) w_next = w_rx_s ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (w_rx_s) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
   always_comb begin
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_shift_en  = 1'b0;
      w_byte_done = 1'b0;
      w_frame_err = 1'b0;
      unique case (r_state)
         START: begin
            w_cnt_clr = (r_cnt == C_HALF);
            w_cnt_inc = (r_cnt != C_HALF);
         end
         DATA: begin
            w_shift_en = (r_cnt == C_LAST);
            w_cnt_clr  = (r_cnt == C_LAST);
            w_cnt_inc  = (r_cnt != C_LAST);
         end
         STOP: begin
            w_cnt_clr   = (r_cnt == C_LAST);
            w_cnt_inc   = (r_cnt != C_LAST);
            w_byte_done = (r_cnt == C_LAST) &&  w_rx_s;
            w_frame_err = (r_cnt == C_LAST) && !w_rx_s;
         end
         default: w_cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_dat       <= '0;
         r_stb       <= 1'b0;
         r_err_frame <= 1'b0;
         r_err_ovr   <= 1'b0;
      end else begin
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

         if (r_state != DATA) r_bit_idx <= '0;
         else if (w_shift_en) r_bit_idx <= r_bit_idx + 1'b1;

         if (w_shift_en) r_shift <= {w_rx_s ^ DATA_INVERT, r_shift[UART_DATA_BITS-1:1]};

         r_err_frame <= w_frame_err;
         r_err_ovr   <= w_byte_done && r_stb && !bus.wb_ack_i;

         // An ack in the completion cycle frees the slot for the new byte.
         if (w_byte_done) begin
            if (!r_stb || bus.wb_ack_i) begin
               r_dat <= r_shift;
               r_stb <= 1'b1;
            end
         end else if (r_stb && bus.wb_ack_i) begin
            r_stb <= 1'b0;
         end
      end
   end

   assign bus.wb_dat_o      = r_dat;
   assign bus.wb_stb_o      = r_stb;
   assign bus.err_frame_o   = r_err_frame;
   assign bus.err_overrun_o = r_err_ovr;
endmodule

// File: tb/tb_wb_uart_rx.sv
// Scoreboard bench for wb_uart_rx: directed frames, expected bytes queued at
// send time and popped by monitors when the receivers present a byte.
module tb_wb_uart_rx;
   localparam int T = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_rx = 1'b1;
   logic uart_rx2 = 1'b1;

   wb_uart_rx_if bus();
   wb_uart_rx_if bus2();

   wb_uart_rx #(.TICKS_PER_BAUD(T), .DATA_INVERT(1'b1)) u_dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .uart_rx   (uart_rx),
      .bus       (bus)
   );

   wb_uart_rx #(.TICKS_PER_BAUD(T), .DATA_INVERT(1'b0)) u_dut_std (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .uart_rx   (uart_rx2),
      .bus       (bus2)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned cyc = 0;
   int unsigned last_fall = 0;
   int unsigned load_edge = 0;
   int unsigned frame_edge = 0;
   int unsigned ovr_edge = 0;
   int unsigned n_frame = 0;
   int unsigned n_ovr = 0;
   int unsigned exp_frame = 0;
   int unsigned exp_ovr = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_q2[$];
   logic stb_prev = 1'b0;
   logic stb2_prev = 1'b0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor for the inverted-data receiver.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         stb_prev = 1'b0;
      end else begin
         if (bus.wb_stb_o && (!stb_prev || bus.wb_ack_i)) begin
            load_edge = cyc;
            if (exp_q.size() == 0) check("rx_byte_expected", 0, 1);
            else                   check("rx_byte", bus.wb_dat_o, exp_q.pop_front());
         end
         if (bus.err_frame_o)   begin n_frame++; frame_edge = cyc; end
         if (bus.err_overrun_o) begin n_ovr++;   ovr_edge   = cyc; end
         stb_prev = bus.wb_stb_o;
      end
   end

   // Monitor for the standard-polarity receiver (always acked).
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         stb2_prev = 1'b0;
      end else begin
         if (bus2.wb_stb_o && !stb2_prev) begin
            if (exp_q2.size() == 0) check("rx2_byte_expected", 0, 1);
            else                    check("rx2_byte", bus2.wb_dat_o, exp_q2.pop_front());
         end
         stb2_prev = bus2.wb_stb_o;
      end
   end

   task automatic drive(input bit which, input logic v);
      if (which) uart_rx2 = v;
      else       uart_rx  = v;
   endtask

   // Call at a negedge; returns at a negedge exactly 10 bit periods later.
   task automatic send(input logic [7:0] b, input logic stop_bit, input bit which);
      drive(which, 1'b0);
      last_fall = cyc + 1;
      repeat (T) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(which, b[i] ^ !which);
         repeat (T) @(negedge clk);
      end
      drive(which, stop_bit);
      repeat (T) @(negedge clk);
   endtask

   task automatic ack_pulse();
      bus.wb_ack_i = 1'b1;
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
   endtask

   task automatic check_errs(input string tag);
      check({tag, "_frame_cnt"}, n_frame, exp_frame);
      check({tag, "_ovr_cnt"}, n_ovr, exp_ovr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at edge %0d, want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      int unsigned fall1;
      bus.wb_ack_i  = 1'b0;
      bus2.wb_ack_i = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dat", bus.wb_dat_o, 0);
      check("rst_stb", bus.wb_stb_o, 0);
      check("rst_errs", {bus.err_frame_o, bus.err_overrun_o}, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: 0xA5, latency and ack
      exp_q.push_back(8'hA5);
      send(8'hA5, 1'b1, 1'b0);
      check("t1_latency", load_edge, last_fall + 78);
      check("t1_stb", bus.wb_stb_o, 1);
      ack_pulse();
      check("t1_stb_after_ack", bus.wb_stb_o, 0);
      check("t1_dat_kept", bus.wb_dat_o, 8'hA5);
      check_errs("t1");

      // 2: start glitch, then 0x3C
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      check("t2_no_stb", bus.wb_stb_o, 0);
      exp_q.push_back(8'h3C);
      send(8'h3C, 1'b1, 1'b0);
      check("t2_stb", bus.wb_stb_o, 1);
      ack_pulse();
      check_errs("t2");

      // 3: framing error, break, then 0x0F
      send(8'h55, 1'b0, 1'b0);
      exp_frame++;
      check("t3_frame_edge", frame_edge, last_fall + 78);
      repeat (30 * T) @(negedge clk);
      check("t3_no_stb_in_break", bus.wb_stb_o, 0);
      uart_rx = 1'b1;
      repeat (3 * T) @(negedge clk);
      exp_q.push_back(8'h0F);
      send(8'h0F, 1'b1, 1'b0);
      check("t3_stb", bus.wb_stb_o, 1);
      ack_pulse();
      check_errs("t3");

      // 4a: back-to-back without ack -> overrun
      exp_q.push_back(8'h11);
      fall1 = cyc + 1;
      send(8'h11, 1'b1, 1'b0);
      send(8'h22, 1'b1, 1'b0);
      exp_ovr++;
      check("t4a_ovr_edge", ovr_edge, fall1 + 80 + 78);
      check("t4a_dat_kept", bus.wb_dat_o, 8'h11);
      check_errs("t4a");
      ack_pulse();
      check("t4a_stb_cleared", bus.wb_stb_o, 0);

      // 4b: back-to-back with ack in the second completion cycle
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      base = cyc + 1;
      fork
         begin
            send(8'h11, 1'b1, 1'b0);
            send(8'h22, 1'b1, 1'b0);
         end
         begin
            while (cyc != base + 80 + 77) @(negedge clk);
            ack_pulse();
         end
      join
      check("t4b_dat", bus.wb_dat_o, 8'h22);
      check("t4b_stb", bus.wb_stb_o, 1);
      check_errs("t4b");

      // 5: reset mid-DATA of 0xFF (0x22 still pending), then 0x81
      fork
         send(8'hFF, 1'b1, 1'b0);
         begin
            repeat (40) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("t5_rst_dat", bus.wb_dat_o, 0);
            check("t5_rst_stb", bus.wb_stb_o, 0);
         end
      join
      check("t5_rst_hold_stb", bus.wb_stb_o, 0);
      check("t5_rst_hold_errs", {bus.err_frame_o, bus.err_overrun_o}, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1, 1'b0);
      check("t5_latency", load_edge, last_fall + 78);
      check("t5_dat", bus.wb_dat_o, 8'h81);
      ack_pulse();
      check_errs("t5");

      // 5b: standard polarity build
      exp_q2.push_back(8'h81);
      send(8'h81, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      check("t5b_dat", bus2.wb_dat_o, 8'h81);

      check("queue_drained", exp_q.size(), 0);
      check("queue2_drained", exp_q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_uart_rx.md
Name: wb_uart_rx

Overview:
- UART receiver that is the downstream neighbour of the team's UART TX stage. It consumes the serial line that stage drives.
- It oversamples the line at TICKS_PER_BAUD clocks per bit, recovers 8N1 frames and presents each byte on a Wishbone-style strobe/ack output.
- It flags framing errors and overruns.
- It sits between the board UART RX pin and the SoC's byte sink (RX FIFO or CPU register).

Parameters:
- TICKS_PER_BAUD, 8, clock cycles per bit period. Must be even and >= 4. H = TICKS_PER_BAUD/2.
- DATA_INVERT, 1, 1 = data bits on the line are the complement of the byte (team TX line convention); 0 = standard UART polarity. Start and stop bits are unaffected.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- uart_rx  in  1  raw serial input, asynchronous to wb_clk_i, idle high.
- wb_dat_o  out  8  received byte.
- wb_stb_o  out  1  byte valid; level signal, held until acknowledged.
- wb_ack_i  in  1  consumer accepts wb_dat_o in the cycle where wb_stb_o and wb_ack_i are both 1.
- err_frame_o  out  1  one-cycle pulse: stop bit sampled low.
- err_overrun_o  out  1  one-cycle pulse: a byte completed while the previous byte was unaccepted.

Behaviour:
- Reset: async assert. wb_dat_o=0, wb_stb_o=0, err_*=0, state=IDLE, counter=0, shift=0. Both synchronizer flops reset to 1 (idle line). Deassertion takes effect on the next clock edge.
- Synchronizer: uart_rx passes through 2 flops to give rx_s. All logic uses rx_s only.
- Counter: width $clog2(TICKS_PER_BAUD). It never exceeds TICKS_PER_BAUD-1.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: counter held at 0. When rx_s==0, go to START.
  - START: counter increments each cycle. At counter==H-1, sample rx_s:
    - 1 (glitch): return to IDLE. No error.
    - 0: go to DATA, counter=0, bit index=0.
  - DATA: at counter==TICKS_PER_BAUD-1 (mid-bit), sample rx_s XOR DATA_INVERT into shift register LSB-first, then reset counter. After the 8th sample, go to STOP, counter=0.
  - STOP: at counter==TICKS_PER_BAUD-1, sample rx_s:
    - 1: byte complete, go to IDLE at mid-stop so back-to-back frames are caught.
    - 0: err_frame_o pulses for 1 cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers a line held low (break) without spurious frames.
- Latency: raw fall captured at edge e gives k=e+2 (IDLE sees rx_s low). Stop sample at edge k+H+9*TICKS_PER_BAUD. wb_stb_o is high after that edge; for TICKS=8 that is edge e+78.
- Byte completion:
  - wb_stb_o=0: load wb_dat_o, set wb_stb_o=1.
  - wb_stb_o=1 with wb_ack_i=1 in the same cycle: load the new byte, wb_stb_o stays 1, no overrun.
  - wb_stb_o=1 with wb_ack_i=0: keep the old byte, drop the new one, pulse err_overrun_o.
- Ack without completion: wb_stb_o falls the next cycle. wb_dat_o keeps its value. Ack while wb_stb_o=0 is ignored.
- Frame error and overrun are mutually exclusive per frame.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is lost.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - UART_DATA_BITS=8.
  - function computing counter width from TICKS_PER_BAUD.
  - shared with the TX stage later.
- Sub-module uart_sync_2ff: 2-flop synchronizer with reset value parameter (default 1) and async active-low reset. Instantiated once.

Test Plan:
1. TICKS=8, DATA_INVERT=1, send 0xA5 (line bits = ~0xA5 LSB-first), wb_ack_i=0 -> wb_stb_o rises 78 edges after the falling edge, wb_dat_o=0xA5, no error pulses. Then ack -> wb_stb_o=0 next cycle.
2. Start glitch: uart_rx low for 2 cycles, then high -> FSM returns to IDLE, wb_stb_o stays 0, no err pulses. A subsequent valid 0x3C frame is received correctly.
3. Stop bit forced low after sending 0x55, line held low 30 bit times, then high, then 0x0F sent -> err_frame_o single pulse, no stb for 0x55, no further frames during the low period, 0x0F received.
4. Back-to-back 0x11 then 0x22 (no idle gap), no ack -> wb_dat_o=0x11 kept, err_overrun_o pulses once at the second stop sample. Repeat with ack asserted in the completion cycle -> wb_dat_o=0x22, no overrun.
5. Assert wb_rst_ni low mid-DATA of 0xFF, release, send 0x81 -> all outputs 0 during reset, 0x81 received cleanly. DATA_INVERT=0 build: standard-polarity 0x81 also decodes to 0x81.
